ref_arb: RTL
============

Name: ref_arb

Overview:
DRAM refresh arbiter/sequencer between the FSB RAM controller and the refresh timer's RefReq/RefUrg outputs.
- Runs exactly one CAS-before-RAS refresh per timer period.
- Refreshes opportunistically when the bus is idle.
- When RefUrg is high, holds off new CPU RAM cycles so refresh can proceed.
- Drives refresh strobe requests into the RAM controller and a hold to the CPU RAM cycle starter.

Parameters:
RAS_CYC, 3, CLK cycles refresh RAS+CAS held asserted (legal 1..15)
PRE_CYC, 2, CLK cycles precharge after refresh, strobes off (legal 1..15)

Ports:
CLK  in  1  FSB clock; all state on rising edge
nRES  in  1  asynchronous active-low reset
RefReq  in  1  refresh period open (high timer states 1..10, low state 0)
RefUrg  in  1  refresh urgent (late in period)
BACT  in  1  CPU bus cycle active
RAMCS  in  1  current CPU cycle targets RAM
RAMHold  out  1  block start of new CPU RAM cycle
RefCAS  out  1  RAM controller drives nCAS low for refresh
RefRAS  out  1  RAM controller drives nRAS low for refresh
RefBusy  out  1  refresh sequence in progress (CAS/RAS/PRE)
MissCnt  out  8  missed-period count (see Optional Feature)

Behaviour:
- Reset (nRES low, async): state IDLE, Served=0, RefReqr=0, counter=0, all outputs 0. Reset mid-sequence aborts immediately; strobes drop with nRES.
- All outputs are registered, 1-cycle latency from sampled inputs.
- RAMBusy = BACT && RAMCS (combinational).
- RefReqr = RefReq delayed one cycle. PeriodEnd = RefReqr && !RefReq.

FSM states:
- IDLE: if RefReq && !Served:
  - if !BACT -> CAS.
  - else if RefUrg -> WAIT.
- WAIT: RAMHold=1.
  - if !RAMBusy -> CAS.
  - if PeriodEnd first -> IDLE, counts a miss; the RAMBusy check takes priority if both occur.
- CAS: RefCAS=1, RAMHold=1, RefBusy=1 for exactly 1 cycle -> RAS. Served set on entry to RAS.
- RAS: RefCAS=1, RefRAS=1, RAMHold=1, RefBusy=1 for RAS_CYC cycles -> PRE.
- PRE: strobes 0, RAMHold=1, RefBusy=1 for PRE_CYC cycles -> DONE.
- DONE: all outputs 0; wait for RefReq==0 -> IDLE.

Served and PeriodEnd rules:
- Served cleared whenever RefReq==0 is sampled in IDLE or DONE.
- PeriodEnd during CAS/RAS/PRE does not abort; the sequence completes and counts as served for the closing period; FSM still goes DONE->IDLE.
- PeriodEnd in IDLE with !Served is a missed period.

Other rules:
- RAMHold never preempts an active CPU cycle; it only gates new starts.
- A CPU RAM cycle beginning in the same cycle IDLE->CAS is decided is the CPU's: the transition is taken only when !BACT was sampled.
- Counter is 4-bit down-counter, loaded with (N-1) on state entry; exits when 0.
- At most one refresh per RefReq high interval.

Optional Feature:
REF_MISS_CNT_EN
- Defined: 8-bit MissCnt increments on each missed period (PeriodEnd with !Served in IDLE/WAIT).
  - Saturates at 255; no wrap.
  - Cleared only by nRES.
- Undefined: counter logic not built; MissCnt constant 0.

Test Plan:
1. Reset/idle: nRES low with RefReq=1, BACT=0 -> all outputs 0. Release -> next cycle RefCAS=1; then 3 cycles RefCAS=RefRAS=1; then 2 cycles RefBusy=1, strobes 0; then DONE, outputs 0.
2. One per period: hold RefReq=1 for 200 cycles, BACT=0 -> exactly one CAS/RAS/PRE sequence. RefReq low 5 cycles then high -> second sequence starts.
3. Urgent wait:
   - BACT=RAMCS=1 continuously, RefReq=1, RefUrg rises -> RAMHold=1 next cycle, no strobes.
   - Drop BACT -> RefCAS=1 one cycle later; RAMHold stays 1 through PRE and is 0 in DONE.
4. Miss: BACT=RAMCS=1 continuously while RefReq high then low, RefUrg=0 -> no refresh, FSM IDLE. With REF_MISS_CNT_EN, MissCnt 0->1; after 300 such periods MissCnt=255.
5. Period end mid-sequence: RefReq falls during RAS -> RAS/PRE complete full length, no miss counted, FSM DONE->IDLE.
6. Reset mid-sequence: assert nRES during RAS cycle 2 -> RefRAS/RefCAS/RAMHold 0 immediately. After release with RefReq=1, BACT=0 -> fresh full sequence.

Source files
------------

// File: rtl/ref_arb_if.sv
// Signal bundle between the DRAM refresh arbiter, the refresh timer,
// the CPU RAM cycle starter and the RAM controller.
interface ref_arb_if;
    logic       RefReq;
    logic       RefUrg;
    logic       BACT;
    logic       RAMCS;
    logic       RAMHold;
    logic       RefCAS;
    logic       RefRAS;
    logic       RefBusy;
    logic [7:0] MissCnt;

    modport master (
        output RefReq, RefUrg, BACT, RAMCS,
        input  RAMHold, RefCAS, RefRAS, RefBusy, MissCnt
    );

    modport slave (
        input  RefReq, RefUrg, BACT, RAMCS,
        output RAMHold, RefCAS, RefRAS, RefBusy, MissCnt
    );
endinterface

// File: rtl/ref_arb.sv
// DRAM refresh arbiter: one CAS-before-RAS refresh per timer period, with urgent CPU hold-off.
// Optional missed-period counter enabled by defining REF_MISS_CNT_EN.
module ref_arb #(
    parameter int unsigned RAS_CYC = 3,
    parameter int unsigned PRE_CYC = 2
) (
    input  logic      CLK,
    input  logic      nRES,
    ref_arb_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, WAIT, CAS, RAS, PRE, DONE} state_t;

    localparam logic [3:0] RAS_LOAD = 4'(RAS_CYC - 1);
    localparam logic [3:0] PRE_LOAD = 4'(PRE_CYC - 1);

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       served, served_next;
    logic       ref_req_r;
    logic       ram_busy, period_end;
    logic       hold_d, cas_d, ras_d, busy_d;
    logic       hold_q, cas_q, ras_q, busy_q;

    assign ram_busy   = bus.BACT && bus.RAMCS;
    assign period_end = ref_req_r && !bus.RefReq;

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            served    <= 1'b0;
            ref_req_r <= 1'b0;
            hold_q    <= 1'b0;
            cas_q     <= 1'b0;
            ras_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            served    <= served_next;
            ref_req_r <= bus.RefReq;
            hold_q    <= hold_d;
            cas_q     <= cas_d;
            ras_q     <= ras_d;
            busy_q    <= busy_d;
        end
    end

    // Outputs are decoded from the next state so they appear registered alongside it.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        served_next = served;
        case (state)
            IDLE: begin
                if (!bus.RefReq) begin
                    served_next = 1'b0;
                end
                if (bus.RefReq && !served) begin
                    if (!bus.BACT) begin
                        state_next = CAS;
                    end else if (bus.RefUrg) begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!ram_busy) begin
                    state_next = CAS;
                end else if (period_end) begin
                    state_next = IDLE;
                end
            end
            CAS: begin
                state_next  = RAS;
                cnt_next    = RAS_LOAD;
                served_next = 1'b1;
            end
            RAS: begin
                if (cnt == 4'd0) begin
                    state_next = PRE;
                    cnt_next   = PRE_LOAD;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            PRE: begin
                if (cnt == 4'd0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            DONE: begin
                if (!bus.RefReq) begin
                    state_next  = IDLE;
                    served_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        hold_d = (state_next == WAIT) || (state_next == CAS) ||
                 (state_next == RAS)  || (state_next == PRE);
        cas_d  = (state_next == CAS)  || (state_next == RAS);
        ras_d  = (state_next == RAS);
        busy_d = (state_next == CAS)  || (state_next == RAS) || (state_next == PRE);
    end

    assign bus.RAMHold = hold_q;
    assign bus.RefCAS  = cas_q;
    assign bus.RefRAS  = ras_q;
    assign bus.RefBusy = busy_q;

`ifdef REF_MISS_CNT_EN
    logic       missed;
    logic [7:0] miss_cnt;

    // A period closing while still waiting (IDLE or blocked in WAIT) was never refreshed.
    assign missed = period_end && !served &&
                    ((state == IDLE) || ((state == WAIT) && ram_busy));

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            miss_cnt <= 8'd0;
        end else if (missed && (miss_cnt != 8'hFF)) begin
            miss_cnt <= miss_cnt + 8'd1;
        end
    end

    assign bus.MissCnt = miss_cnt;
`else
    assign bus.MissCnt = 8'd0;
`endif

endmodule
